// File: rtl/verification_stimulus.sv
// Stimulus driver for the SECDED encoder/decoder bench: generates LFSR data, drives
// alternating encode/decode requests with 0/1/2 injected bit errors and publishes golden values.
module verification_stimulus #(
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_BITS = (DATA_WIDTH <= 4)  ? 3 :
                               (DATA_WIDTH <= 11) ? 4 :
                               (DATA_WIDTH <= 26) ? 5 : 6,
   parameter int CW          = DATA_WIDTH + PARITY_BITS + 1,
   parameter int TIMEOUT     = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [15:0]           num_transactions,
   input  logic [31:0]           seed,
   input  logic                  operation_done,
   output logic                  op_valid,
   output logic [1:0]            type_of_work,
   output logic [CW-1:0]         data_in,
   output logic [CW-1:0]         encoded_data_in,
   output logic [DATA_WIDTH-1:0] decoded_data_in,
   output logic [1:0]            stim_num_of_errors,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err,
   output logic [15:0]           txn_count
);

   localparam int WW = $clog2(TIMEOUT) + 1;
   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

   typedef enum logic [2:0] {IDLE, GEN, DRIVE, WAIT, GAP, FINISH} state_t;

   state_t                state_q, state_d;
   logic [31:0]           lfsr_q, lfsr_d;
   logic [15:0]           numTxn_q, numTxn_d;
   logic [15:0]           txnCount_q, txnCount_d;
   logic [1:0]            errSel_q, errSel_d;
   logic [WW-1:0]         waitCnt_q, waitCnt_d;
   logic                  timeoutErr_q, timeoutErr_d;
   logic                  opValid_q, opValid_d;
   logic [1:0]            typeOfWork_q, typeOfWork_d;
   logic [CW-1:0]         dataIn_q, dataIn_d;
   logic [CW-1:0]         encoded_q, encoded_d;
   logic [DATA_WIDTH-1:0] decoded_q, decoded_d;
   logic [1:0]            numErr_q, numErr_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [CW-1:0]         cwNew;
   logic [CW-1:0]         errMask;
   logic [7:0]            pos1, pos2;

   // Hamming positions 1..CW-1 with parity at powers of two, bit 0 is overall parity
   function automatic logic [CW-1:0] hamming(input logic [DATA_WIDTH-1:0] d);
      logic [CW-1:0] c;
      logic          par;
      int            k;
      c = '0;
      k = 0;
      for (int pos = 1; pos < CW; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            c[pos] = d[k];
            k++;
         end
      end
      for (int p = 0; p < PARITY_BITS; p++) begin
         par = 1'b0;
         for (int pos = 1; pos < CW; pos++) begin
            if (((pos >> p) & 1) != 0) par = par ^ c[pos];
         end
         c[1 << p] = par;
      end
      c[0] = ^c[CW-1:1];
      return c;
   endfunction

   always_comb begin
      cwNew = hamming(lfsr_q[DATA_WIDTH-1:0]);
      pos1  = 8'(32'(lfsr_q[15:8]) % CW);
      pos2  = 8'((32'(pos1) + 32'd1 + (32'(lfsr_q[23:16]) % (CW - 1))) % CW);
      errMask = '0;
      if (errSel_q != 2'd0) errMask = errMask | (CW'(1) << pos1);
      if (errSel_q == 2'd2) errMask = errMask | (CW'(1) << pos2);
   end

   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      numTxn_d     = numTxn_q;
      txnCount_d   = txnCount_q;
      errSel_d     = errSel_q;
      waitCnt_d    = waitCnt_q;
      timeoutErr_d = timeoutErr_q;
      typeOfWork_d = typeOfWork_q;
      dataIn_d     = dataIn_q;
      encoded_d    = encoded_q;
      decoded_d    = decoded_q;
      numErr_d     = numErr_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = GEN;
               lfsr_d       = (seed == 32'd0) ? 32'd1 : seed;
               numTxn_d     = (num_transactions == 16'd0) ? 16'd1 : num_transactions;
               txnCount_d   = '0;
               errSel_d     = '0;
               timeoutErr_d = 1'b0;
            end
         end
         GEN: begin
            lfsr_d    = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
            decoded_d = lfsr_q[DATA_WIDTH-1:0];
            encoded_d = cwNew;
            // Even transaction index encodes; the error count cycles over decodes only
            if (!txnCount_q[0]) begin
               typeOfWork_d = 2'd1;
               numErr_d     = 2'd0;
               dataIn_d     = {{(CW-DATA_WIDTH){1'b0}}, lfsr_q[DATA_WIDTH-1:0]};
            end else begin
               typeOfWork_d = 2'd2;
               numErr_d     = errSel_q;
               dataIn_d     = cwNew ^ errMask;
               errSel_d     = (errSel_q == 2'd2) ? 2'd0 : errSel_q + 2'd1;
            end
            state_d = DRIVE;
         end
         DRIVE: begin
            waitCnt_d = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            if (operation_done) begin
               txnCount_d = txnCount_q + 16'd1;
               state_d    = GAP;
            end else if (waitCnt_q == WW'(TIMEOUT - 1)) begin
               timeoutErr_d = 1'b1;
               state_d      = FINISH;
            end else begin
               waitCnt_d = waitCnt_q + WW'(1);
            end
         end
         GAP:     state_d = (txnCount_q < numTxn_q) ? GEN : FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (state_d == GAP || state_d == FINISH) typeOfWork_d = 2'd0;
      opValid_d = (state_d == DRIVE);
      busy_d    = (state_d != IDLE);
      done_d    = (state_q == FINISH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         lfsr_q       <= 32'd1;
         numTxn_q     <= '0;
         txnCount_q   <= '0;
         errSel_q     <= '0;
         waitCnt_q    <= '0;
         timeoutErr_q <= 1'b0;
         opValid_q    <= 1'b0;
         typeOfWork_q <= '0;
         dataIn_q     <= '0;
         encoded_q    <= '0;
         decoded_q    <= '0;
         numErr_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         numTxn_q     <= numTxn_d;
         txnCount_q   <= txnCount_d;
         errSel_q     <= errSel_d;
         waitCnt_q    <= waitCnt_d;
         timeoutErr_q <= timeoutErr_d;
         opValid_q    <= opValid_d;
         typeOfWork_q <= typeOfWork_d;
         dataIn_q     <= dataIn_d;
         encoded_q    <= encoded_d;
         decoded_q    <= decoded_d;
         numErr_q     <= numErr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign op_valid           = opValid_q;
   assign type_of_work       = typeOfWork_q;
   assign data_in            = dataIn_q;
   assign encoded_data_in    = encoded_q;
   assign decoded_data_in    = decoded_q;
   assign stim_num_of_errors = numErr_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign timeout_err        = timeoutErr_q;
   assign txn_count          = txnCount_q;

endmodule

// File: tb/tb_verification_stimulus.sv
// Randomized bench for verification_stimulus: a transaction-level reference model predicts
// every request, and a responder acknowledges with configurable latency.
module tb_verification_stimulus;

   localparam int DW      = 8;
   localparam int CW      = 13;
   localparam int TIMEOUT = 64;

   typedef struct {
      logic [1:0]    mode;
      logic [DW-1:0] data;
      logic [CW-1:0] cw;
      logic [1:0]    nerr;
      logic [CW-1:0] din;
   } txn_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [15:0]   num_transactions;
   logic [31:0]   seed;
   logic          operation_done;
   logic          op_valid;
   logic [1:0]    type_of_work;
   logic [CW-1:0] data_in;
   logic [CW-1:0] encoded_data_in;
   logic [DW-1:0] decoded_data_in;
   logic [1:0]    stim_num_of_errors;
   logic          busy;
   logic          done;
   logic          timeout_err;
   logic [15:0]   txn_count;

   int   assertCount = 0;
   int   failCount   = 0;
   txn_t expQ[$];

   verification_stimulus #(.DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .num_transactions   (num_transactions),
      .seed               (seed),
      .operation_done     (operation_done),
      .op_valid           (op_valid),
      .type_of_work       (type_of_work),
      .data_in            (data_in),
      .encoded_data_in    (encoded_data_in),
      .decoded_data_in    (decoded_data_in),
      .stim_num_of_errors (stim_num_of_errors),
      .busy               (busy),
      .done               (done),
      .timeout_err        (timeout_err),
      .txn_count          (txn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Build the codeword straight from the placement rules, using position masks
   function automatic logic [CW-1:0] refEncode(input logic [DW-1:0] d);
      longint unsigned v, m;
      int k;
      v = 0;
      k = 0;
      for (int pos = 1; pos < CW; pos++) begin
         if ($countones(pos) != 1) begin
            if (d[k]) v = v | (64'd1 << pos);
            k++;
         end
      end
      for (int p = 0; (1 << p) < CW; p++) begin
         m = 0;
         for (int pos = 1; pos < CW; pos++)
            if ((pos & (1 << p)) != 0) m = m | (64'd1 << pos);
         if (($countones(v & m) % 2) == 1) v = v | (64'd1 << (1 << p));
      end
      if (($countones(v) % 2) == 1) v = v | 64'd1;
      return CW'(v);
   endfunction

   task automatic buildExpected(input logic [31:0] s, input int nEff);
      int unsigned lfsr;
      int unsigned p1, p2;
      int decIdx;
      txn_t t;
      expQ.delete();
      lfsr   = (s == 0) ? 32'd1 : s;
      decIdx = 0;
      for (int i = 0; i < nEff; i++) begin
         t.data = lfsr[DW-1:0];
         t.cw   = refEncode(t.data);
         p1     = ((lfsr >> 8) & 255) % CW;
         p2     = (p1 + 1 + (((lfsr >> 16) & 255) % (CW - 1))) % CW;
         if (i % 2 == 0) begin
            t.mode = 2'd1;
            t.nerr = 2'd0;
            t.din  = CW'(t.data);
         end else begin
            t.mode = 2'd2;
            t.nerr = 2'(decIdx % 3);
            t.din  = t.cw;
            if (t.nerr >= 1) t.din[p1] = ~t.din[p1];
            if (t.nerr == 2) t.din[p2] = ~t.din[p2];
            decIdx++;
         end
         expQ.push_back(t);
         lfsr = (lfsr >> 1) ^ ((lfsr & 1) != 0 ? 32'h8020_0003 : 32'd0);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] s, input logic [15:0] n);
      @(negedge clk);
      seed             = s;
      num_transactions = n;
      start            = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic runAndCheck(input logic [31:0] s, input logic [15:0] n, input int lat,
                              input bit pokeStart, input bit pokeDoneGap);
      int nEff;
      int cnt;
      nEff = (n == 0) ? 1 : int'(n);
      buildExpected(s, nEff);
      applyStimulus(s, n);
      checkOutput("busyAfterStart", 64'(busy), 64'd1);
      checkOutput("timeoutClearedOnStart", 64'(timeout_err), 64'd0);
      for (int i = 0; i < nEff; i++) begin
         cnt = 0;
         while (!op_valid && cnt < 16) begin
            @(negedge clk);
            cnt++;
         end
         if (!op_valid) begin
            checkOutput("opValidSeen", 64'd0, 64'd1);
            return;
         end
         if (i == 0) checkOutput("firstOpLatency", 64'(cnt), 64'd1);
         checkOutput("typeOfWork", 64'(type_of_work), 64'(expQ[i].mode));
         checkOutput("decodedData", 64'(decoded_data_in), 64'(expQ[i].data));
         checkOutput("encodedData", 64'(encoded_data_in), 64'(expQ[i].cw));
         checkOutput("numErrors", 64'(stim_num_of_errors), 64'(expQ[i].nerr));
         checkOutput("dataIn", 64'(data_in), 64'(expQ[i].din));
         if (expQ[i].mode == 2'd2)
            checkOutput("errorPopcount", 64'($countones(data_in ^ encoded_data_in)), 64'(expQ[i].nerr));
         checkOutput("overallParity", 64'(^encoded_data_in), 64'd0);
         if (pokeStart) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         checkOutput("opValidPulse", 64'(op_valid), 64'd0);
         repeat (lat - 1) @(negedge clk);
         operation_done = 1'b1;
         @(negedge clk);
         operation_done = 1'b0;
         checkOutput("txnCount", 64'(txn_count), 64'(i + 1));
         checkOutput("typeInGap", 64'(type_of_work), 64'd0);
         if (pokeDoneGap) begin
            operation_done = 1'b1;
            @(negedge clk);
            operation_done = 1'b0;
         end
      end
      cnt = pokeDoneGap ? 1 : 0;
      while (!done && cnt < 16) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("doneSeen", 64'(done), 64'd1);
      checkOutput("doneLatency", 64'(cnt), 64'd2);
      checkOutput("finalCount", 64'(txn_count), 64'(nEff));
      checkOutput("busyAtDone", 64'(busy), 64'd0);
      checkOutput("noTimeout", 64'(timeout_err), 64'd0);
      @(negedge clk);
      checkOutput("donePulse", 64'(done), 64'd0);
   endtask

   task automatic checkTimeout();
      int cnt;
      applyStimulus(32'h1234_5678, 16'd3);
      cnt = 0;
      while (!op_valid && cnt < 16) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("timeoutOpValid", 64'(op_valid), 64'd1);
      cnt = 0;
      while (!timeout_err && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      // WAIT starts one edge after the DRIVE sample, so the flag shows TIMEOUT+1 samples later
      checkOutput("timeoutLatency", 64'(cnt), 64'(TIMEOUT + 1));
      checkOutput("timeoutDoneNotYet", 64'(done), 64'd0);
      @(negedge clk);
      checkOutput("timeoutDone", 64'(done), 64'd1);
      checkOutput("timeoutBusy", 64'(busy), 64'd0);
      checkOutput("timeoutCount", 64'(txn_count), 64'd0);
      @(negedge clk);
      checkOutput("timeoutSticky", 64'(timeout_err), 64'd1);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tag, "_opValid"}, 64'(op_valid), 64'd0);
      checkOutput({tag, "_type"}, 64'(type_of_work), 64'd0);
      checkOutput({tag, "_dataIn"}, 64'(data_in), 64'd0);
      checkOutput({tag, "_encoded"}, 64'(encoded_data_in), 64'd0);
      checkOutput({tag, "_decoded"}, 64'(decoded_data_in), 64'd0);
      checkOutput({tag, "_nerr"}, 64'(stim_num_of_errors), 64'd0);
      checkOutput({tag, "_done"}, 64'(done), 64'd0);
      checkOutput({tag, "_timeout"}, 64'(timeout_err), 64'd0);
      checkOutput({tag, "_count"}, 64'(txn_count), 64'd0);
   endtask

   task automatic checkResetMidRun();
      int cnt;
      applyStimulus(32'hCAFE_F00D, 16'd4);
      cnt = 0;
      while (!op_valid && cnt < 16) begin
         @(negedge clk);
         cnt++;
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkResetValues("midReset");
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst              = 1'b0;
      start            = 1'b0;
      num_transactions = '0;
      seed             = '0;
      operation_done   = 1'b0;
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      rst = 1'b1;

      $display("[TB] directed encode of 0xFF");
      runAndCheck(32'h0000_00FF, 16'd1, 1, 1'b0, 1'b0);
      $display("[TB] zero seed, six transactions");
      runAndCheck(32'h0000_0000, 16'd6, 1, 1'b0, 1'b0);
      $display("[TB] reset during WAIT");
      checkResetMidRun();
      runAndCheck(32'h0BAD_BEEF, 16'd3, 2, 1'b0, 1'b0);
      $display("[TB] ignored start and late acknowledge");
      runAndCheck($urandom, 16'd4, 2, 1'b1, 1'b1);
      $display("[TB] zero transaction count");
      runAndCheck($urandom, 16'd0, 1, 1'b0, 1'b0);
      $display("[TB] timeout");
      checkTimeout();
      $display("[TB] randomized runs");
      for (int r = 0; r < 6; r++)
         runAndCheck($urandom, 16'($urandom_range(1, 8)), int'($urandom_range(1, 4)), 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
